// File: rtl/wb_regfile.sv
// Architectural register file with a per-register busy scoreboard: two writeback ports, two read ports, issue stall.
// Optional same-cycle read bypass from the writeback ports when REGFILE_BYPASS_EN is defined.
module wb_regfile #(
  parameter int unsigned NREG = 32,
  parameter int unsigned DW   = 32
) (
  input  logic          clock2,
  input  logic          reset,
  input  logic [1:0]    wb_en,
  input  logic [4:0]    wb_dest,
  input  logic [DW-1:0] wb_data1,
  input  logic [DW-1:0] wb_data2,
  input  logic [4:0]    rs_addr,
  input  logic [4:0]    rt_addr,
  output logic [DW-1:0] rs_data,
  output logic [DW-1:0] rt_data,
  input  logic          issue_valid,
  input  logic [4:0]    issue_dest,
  input  logic          issue_pair,
  input  logic          issue_uses_rt,
  output logic          stall,
  output logic [5:0]    pending
);

  localparam int unsigned AW = 5;
  localparam int unsigned CW = 6;

  logic [DW-1:0]   regs [NREG];
  logic [NREG-1:0] busy;
  logic [NREG-1:0] clr;
  logic [NREG-1:0] set;
  logic [NREG-1:0] busy_eff;
  logic [NREG-1:0] busy_next;
  logic [CW-1:0]   inc;
  logic [CW-1:0]   dec;
  logic [CW-1:0]   pending_next;
  logic [AW-1:0]   dest2;
  logic [AW-1:0]   issue_dest2;
  logic            wr1;
  logic            wr2;
  logic            accept;

  // One-hot of a register index, never selecting r0.
  function automatic logic [NREG-1:0] onehot(input logic [AW-1:0] a, input logic en);
    logic [NREG-1:0] v;
    v = '0;
    for (int unsigned i = 1; i < NREG; i++)
      if (en && (a == AW'(i))) v[i] = 1'b1;
    return v;
  endfunction

  function automatic logic is_busy(input logic [NREG-1:0] v, input logic [AW-1:0] a);
    logic b;
    b = 1'b0;
    for (int unsigned i = 1; i < NREG; i++)
      if (a == AW'(i)) b = v[i];
    return b;
  endfunction

  function automatic logic [CW-1:0] popcnt(input logic [NREG-1:0] v);
    logic [CW-1:0] n;
    n = '0;
    for (int unsigned i = 0; i < NREG; i++)
      n = n + CW'(v[i]);
    return n;
  endfunction

  // Writeback decode; writes are suppressed while reset is held.
  always_comb begin
    dest2       = wb_dest + AW'(1);
    issue_dest2 = issue_dest + AW'(1);
    wr1         = ~reset & wb_en[0] & (wb_dest != '0);
    wr2         = ~reset & wb_en[1] & (dest2 != '0);
  end

  // Scoreboard: hazards are checked after this cycle's writeback clears; issue set wins over clear.
  always_comb begin
    clr      = onehot(wb_dest, wr1) | onehot(dest2, wr2);
    busy_eff = busy & ~clr;
    stall    = issue_valid &
               (is_busy(busy_eff, rs_addr) |
                (issue_uses_rt & is_busy(busy_eff, rt_addr)) |
                is_busy(busy_eff, issue_dest) |
                (issue_pair & is_busy(busy_eff, issue_dest2)));
    accept   = issue_valid & ~stall;
    set      = onehot(issue_dest, accept) | onehot(issue_dest2, accept & issue_pair);
    busy_next = busy_eff | set;
    // Count only real transitions so the counter tracks the busy vector exactly.
    inc          = popcnt(set & ~busy);
    dec          = popcnt(clr & busy & ~set);
    pending_next = pending + inc - dec;
  end

  always_comb begin
    rs_data = '0;
    rt_data = '0;
    for (int unsigned i = 1; i < NREG; i++) begin
      if (rs_addr == AW'(i)) rs_data = regs[i];
      if (rt_addr == AW'(i)) rt_data = regs[i];
    end
`ifdef REGFILE_BYPASS_EN
    if (wr1 && (rs_addr == wb_dest))    rs_data = wb_data1;
    else if (wr2 && (rs_addr == dest2)) rs_data = wb_data2;
    if (wr1 && (rt_addr == wb_dest))    rt_data = wb_data1;
    else if (wr2 && (rt_addr == dest2)) rt_data = wb_data2;
`endif
  end

  always_ff @(posedge clock2 or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NREG; i++) regs[i] <= '0;
      busy    <= '0;
      pending <= '0;
    end else begin
      for (int unsigned i = 1; i < NREG; i++) begin
        if (wr1 && (wb_dest == AW'(i))) regs[i] <= wb_data1;
        if (wr2 && (dest2 == AW'(i)))   regs[i] <= wb_data2;
      end
      busy    <= busy_next;
      pending <= pending_next;
    end
  end

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed vector table, reset sequence, randomized run against a scoreboard model.
module tb_wb_regfile;

  logic        clock2;
  logic        reset;
  logic [1:0]  wb_en;
  logic [4:0]  wb_dest;
  logic [31:0] wb_data1;
  logic [31:0] wb_data2;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        issue_valid;
  logic [4:0]  issue_dest;
  logic        issue_pair;
  logic        issue_uses_rt;
  logic        stall;
  logic [5:0]  pending;

  int n_cmp = 0;
  int n_bad = 0;

  wb_regfile #(.NREG(32), .DW(32)) dut (
    .clock2(clock2), .reset(reset), .wb_en(wb_en), .wb_dest(wb_dest),
    .wb_data1(wb_data1), .wb_data2(wb_data2), .rs_addr(rs_addr), .rt_addr(rt_addr),
    .rs_data(rs_data), .rt_data(rt_data), .issue_valid(issue_valid),
    .issue_dest(issue_dest), .issue_pair(issue_pair), .issue_uses_rt(issue_uses_rt),
    .stall(stall), .pending(pending)
  );

  initial clock2 = 1'b0;
  always #5 clock2 = ~clock2;

  typedef struct {
    logic [1:0]  en;
    logic [4:0]  dest;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic        iv;
    logic [4:0]  idest;
    logic        ipair;
    logic        iuse;
    logic        ex_stall;
    logic [31:0] ex_rs;
    logic [31:0] ex_rt;
    logic [5:0]  ex_pend;
  } vec_t;

  vec_t tv [14];

  // Reference model: plain arrays following the architectural rules.
  logic [31:0] m_regs [32];
  bit          m_busy [32];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [1:0] en, input logic [4:0] dest, input logic [31:0] d1,
                              input logic [31:0] d2, input logic [4:0] rs, input logic [4:0] rt,
                              input logic iv, input logic [4:0] idest, input logic ipair, input logic iuse,
                              input logic ex_stall, input logic [31:0] ex_rs, input logic [31:0] ex_rt,
                              input logic [5:0] ex_pend);
    vec_t v;
    v.en = en; v.dest = dest; v.d1 = d1; v.d2 = d2; v.rs = rs; v.rt = rt;
    v.iv = iv; v.idest = idest; v.ipair = ipair; v.iuse = iuse;
    v.ex_stall = ex_stall; v.ex_rs = ex_rs; v.ex_rt = ex_rt; v.ex_pend = ex_pend;
    return v;
  endfunction

  task automatic idle_inputs();
    wb_en = 2'b00; wb_dest = '0; wb_data1 = '0; wb_data2 = '0;
    issue_valid = 1'b0; issue_dest = '0; issue_pair = 1'b0; issue_uses_rt = 1'b0;
  endtask

  function automatic int nxt(input int r);
    return (r + 1) % 32;
  endfunction

  function automatic bit m_cleared(input int r);
    if (r == 0) return 1'b0;
    if (wb_en[0] && int'(wb_dest) == r) return 1'b1;
    if (wb_en[1] && nxt(int'(wb_dest)) == r) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_hazard(input int r);
    return (r != 0) && m_busy[r] && !m_cleared(r);
  endfunction

  function automatic bit m_stall();
    if (!issue_valid) return 1'b0;
    return m_hazard(int'(rs_addr)) || (issue_uses_rt && m_hazard(int'(rt_addr))) ||
           m_hazard(int'(issue_dest)) || (issue_pair && m_hazard(nxt(int'(issue_dest))));
  endfunction

  function automatic logic [31:0] m_read(input int r);
    if (r == 0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
    if (wb_en[0] && int'(wb_dest) == r) return wb_data1;
    if (wb_en[1] && nxt(int'(wb_dest)) == r) return wb_data2;
`endif
    return m_regs[r];
  endfunction

  // Apply one clock edge of architectural effects to the model.
  task automatic m_edge(input bit stl);
    int d2;
    d2 = nxt(int'(wb_dest));
    if (wb_en[0] && wb_dest != 0) begin m_regs[wb_dest] = wb_data1; m_busy[wb_dest] = 1'b0; end
    if (wb_en[1] && d2 != 0)      begin m_regs[d2] = wb_data2;      m_busy[d2] = 1'b0; end
    if (issue_valid && !stl) begin
      if (issue_dest != 0) m_busy[issue_dest] = 1'b1;
      if (issue_pair && nxt(int'(issue_dest)) != 0) m_busy[nxt(int'(issue_dest))] = 1'b1;
    end
  endtask

  function automatic logic [31:0] m_pending();
    int n;
    n = 0;
    for (int i = 0; i < 32; i++) n += int'(m_busy[i]);
    return 32'(n);
  endfunction

  function automatic logic [4:0] rnd_addr();
    if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
    return 5'($urandom_range(0, 7));
  endfunction

  initial begin
    bit stl;

    tv[0]  = mk(2'd1, 5'd1,  32'h15, 32'h0,  5'd1,  5'd0,  1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 32'h15, 32'h0,  6'd0);
    tv[1]  = mk(2'd3, 5'd0,  32'h2,  32'h1,  5'd0,  5'd1,  1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 32'h0,  32'h1,  6'd0);
    tv[2]  = mk(2'd0, 5'd0,  32'h0,  32'h0,  5'd0,  5'd0,  1'b1, 5'd5,  1'b0, 1'b0, 1'b0, 32'h0,  32'h0,  6'd1);
    tv[3]  = mk(2'd0, 5'd0,  32'h0,  32'h0,  5'd5,  5'd0,  1'b1, 5'd6,  1'b0, 1'b0, 1'b1, 32'h0,  32'h0,  6'd1);
    tv[4]  = mk(2'd1, 5'd5,  32'h8,  32'h0,  5'd5,  5'd6,  1'b1, 5'd6,  1'b0, 1'b0, 1'b0, 32'h8,  32'h0,  6'd1);
    tv[5]  = mk(2'd0, 5'd0,  32'h0,  32'h0,  5'd31, 5'd0,  1'b1, 5'd31, 1'b1, 1'b0, 1'b0, 32'h0,  32'h0,  6'd2);
    tv[6]  = mk(2'd0, 5'd0,  32'h0,  32'h0,  5'd0,  5'd0,  1'b1, 5'd30, 1'b1, 1'b0, 1'b1, 32'h0,  32'h0,  6'd2);
    tv[7]  = mk(2'd3, 5'd31, 32'hAA, 32'hBB, 5'd31, 5'd0,  1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 32'hAA, 32'h0,  6'd1);
    tv[8]  = mk(2'd0, 5'd0,  32'h0,  32'h0,  5'd0,  5'd0,  1'b1, 5'd7,  1'b0, 1'b0, 1'b0, 32'h0,  32'h0,  6'd2);
    tv[9]  = mk(2'd1, 5'd7,  32'h77, 32'h0,  5'd7,  5'd0,  1'b1, 5'd7,  1'b0, 1'b0, 1'b0, 32'h77, 32'h0,  6'd2);
    tv[10] = mk(2'd0, 5'd0,  32'h0,  32'h0,  5'd0,  5'd7,  1'b1, 5'd9,  1'b0, 1'b1, 1'b1, 32'h0,  32'h77, 6'd2);
    tv[11] = mk(2'd0, 5'd0,  32'h0,  32'h0,  5'd0,  5'd7,  1'b1, 5'd9,  1'b0, 1'b0, 1'b0, 32'h0,  32'h77, 6'd3);
    tv[12] = mk(2'd0, 5'd0,  32'h0,  32'h0,  5'd0,  5'd0,  1'b1, 5'd0,  1'b0, 1'b0, 1'b0, 32'h0,  32'h0,  6'd3);
    tv[13] = mk(2'd0, 5'd0,  32'h0,  32'h0,  5'd1,  5'd31, 1'b1, 5'd0,  1'b1, 1'b1, 1'b0, 32'h1,  32'hAA, 6'd4);

    // Reset state
    reset = 1'b1; idle_inputs(); rs_addr = 5'd1; rt_addr = 5'd31;
    repeat (2) @(posedge clock2);
    #1;
    check("rst_pending", 32'(pending), 32'h0);
    check("rst_stall", 32'(stall), 32'h0);
    check("rst_rs", rs_data, 32'h0);
    check("rst_rt", rt_data, 32'h0);
    @(negedge clock2);
    reset = 1'b0;

    // Directed vector table
    for (int i = 0; i < 14; i++) begin
      @(negedge clock2);
      wb_en = tv[i].en; wb_dest = tv[i].dest; wb_data1 = tv[i].d1; wb_data2 = tv[i].d2;
      rs_addr = tv[i].rs; rt_addr = tv[i].rt; issue_valid = tv[i].iv; issue_dest = tv[i].idest;
      issue_pair = tv[i].ipair; issue_uses_rt = tv[i].iuse;
      #1;
      check($sformatf("vec%0d_stall", i), 32'(stall), 32'(tv[i].ex_stall));
      @(posedge clock2);
      #1;
      idle_inputs();
      #1;
      check($sformatf("vec%0d_rs", i), rs_data, tv[i].ex_rs);
      check($sformatf("vec%0d_rt", i), rt_data, tv[i].ex_rt);
      check($sformatf("vec%0d_pending", i), 32'(pending), 32'(tv[i].ex_pend));
    end

    // Asynchronous reset between edges with busy registers and live writebacks
    @(negedge clock2);
    #2;
    reset = 1'b1;
    wb_en = 2'b01; wb_dest = 5'd3; wb_data1 = 32'h33;
    #1;
    check("arst_pending", 32'(pending), 32'h0);
    for (int r = 0; r < 32; r += 5) begin
      rs_addr = 5'(r); rt_addr = 5'(31 - r);
      #1;
      check($sformatf("arst_rs%0d", r), rs_data, 32'h0);
      check($sformatf("arst_rt%0d", 31 - r), rt_data, 32'h0);
    end
    issue_valid = 1'b1; issue_dest = 5'd6; rs_addr = 5'd7; rt_addr = 5'd9; issue_uses_rt = 1'b1;
    #1;
    check("arst_stall", 32'(stall), 32'h0);
    @(posedge clock2);
    #1;
    rs_addr = 5'd3;
    #1;
    check("arst_wr_ignored", rs_data, 32'h0);
    @(negedge clock2);
    reset = 1'b0; idle_inputs();
    @(posedge clock2);
    #1;
    check("post_rst_r3", rs_data, 32'h0);
    check("post_rst_pending", 32'(pending), 32'h0);

    // Randomized run against the model
    for (int i = 0; i < 32; i++) begin m_regs[i] = '0; m_busy[i] = 1'b0; end
    for (int c = 0; c < 1500; c++) begin
      @(negedge clock2);
      wb_en         = ($urandom_range(0, 9) < 4) ? 2'b00 : 2'($urandom_range(1, 3));
      wb_dest       = rnd_addr();
      wb_data1      = $urandom;
      wb_data2      = $urandom;
      rs_addr       = rnd_addr();
      rt_addr       = rnd_addr();
      issue_valid   = ($urandom_range(0, 9) < 6);
      issue_dest    = rnd_addr();
      issue_pair    = ($urandom_range(0, 3) == 0);
      issue_uses_rt = 1'($urandom_range(0, 1));
      #1;
      stl = m_stall();
      check("rnd_stall", 32'(stall), 32'(stl));
      check("rnd_rs", rs_data, m_read(int'(rs_addr)));
      check("rnd_rt", rt_data, m_read(int'(rt_addr)));
      @(posedge clock2);
      m_edge(stl);
      #1;
      check("rnd_pending", 32'(pending), m_pending());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/wb_regfile.md
# wb_regfile

Architectural register file and scoreboard at the receiving end of the writeback interface. It accepts up to two register writes per cycle from the writeback stage, as a primary result plus an optional pair result. It serves two combinational read ports to decode. A per-register busy scoreboard is set at issue and cleared at writeback, and produces the decode stall.

## Interface
- `NREG`, default 32: number of registers; index width fixed at 5.
- `DW`, default 32: data width.
- `clock2`  in  1  pipeline clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high; clears all registers, busy bits and counter.
- `wb_en`  in  2  bit0 = write `wb_data1` to `wb_dest`; bit1 = write `wb_data2` to `wb_dest+1` (mod 32).
- `wb_dest`  in  5  writeback destination register.
- `wb_data1`  in  DW  primary result (the writeback stage's result1).
- `wb_data2`  in  DW  pair result (the writeback stage's result2).
- `rs_addr`, `rt_addr`  in  5 each  read addresses.
- `rs_data`, `rt_data`  out  DW each  read data.
- `issue_valid`  in  1  decode requests issue of an instruction.
- `issue_dest`  in  5  destination of the issuing instruction.
- `issue_pair`  in  1  issuing instruction also writes `issue_dest+1`.
- `issue_uses_rt`  in  1  instruction reads rt (rs is always read).
- `stall`  out  1  issue blocked this cycle (combinational).
- `pending`  out  6  number of outstanding busy registers.

## Operation
- Register 0 always reads 0. Writes to r0 are discarded, and r0 is never marked busy.
- Writeback: on each edge, port 1 writes when `wb_en[0]`. Port 2 writes when `wb_en[1]`, to `(wb_dest+1)&31`. Each write clears that register's busy bit.
- The two ports always address different registers, so no intra-cycle collision exists.
- `wb_en==0` means no write. `wb_dest` and the data inputs are then ignored.
- Stall is asserted when `issue_valid` and any of the following is busy:
  - `rs_addr`;
  - `rt_addr`, when `issue_uses_rt`;
  - `issue_dest`;
  - `issue_dest+1`, when `issue_pair`.
  - The test uses busy state after the same-cycle writeback clear, i.e. writeback resolves a hazard in the same cycle.
- Issue accept: `issue_valid & ~stall` sets busy for `issue_dest`, plus `issue_dest+1` when `issue_pair`, skipping r0.
- Simultaneous writeback-clear and issue-set on the same register: the set wins.
- `pending` is the population count of the busy vector. It is held as a registered counter, updated by the sets minus the clears of the cycle.
- Range 0..31. Clearing a non-busy register does not change the counter; there is no underflow.

## Timing
- Reset values:
  - all registers 0;
  - all busy bits 0;
  - `pending`=0;
  - `stall`=0 with `issue_valid`=0.
- Reset asserted mid-operation discards all in-flight state immediately. Writebacks during reset are ignored.
- Write latency: data presented at edge N is visible at the read ports from edge N.
  - With `REGFILE_BYPASS_EN`, it is also visible combinationally before edge N.
- Read ports are combinational from address and stored state.
- `stall` is combinational from the issue inputs, the writeback inputs and the busy vector. It has no registered delay.
- `pending` is updated at the edge following the accept/clear.

## Configuration
- `REGFILE_BYPASS_EN` defined:
  - A read whose address matches an active writeback port (nonzero) returns that port's incoming data in the same cycle.
  - Port 2's address match is checked against `wb_dest+1`.
- Not defined: reads return the stored value only. A same-cycle writeback is visible after the edge.
- Stall logic is identical in both builds.

## Test plan
- Reset, then write r1=0x15 (`wb_en`=1, dest 1); read `rs_addr`=1 -> 0x15 after the edge.
  - In the bypass build, 0x15 is already visible before the edge.
- Pair write: `wb_en`=3, dest 0, data1=0x2, data2=0x1 -> r0 stays 0, r1=0x1, `pending` unchanged.
- Issue with dest 5, then issue reading rs=5 -> `stall`=1.
  - Writeback of r5=0x8 in the same cycle as the second issue -> `stall`=0, and r5 reads 0x8 next cycle.
- Issue `issue_pair` with dest 31 -> busy r31 and r0 skipped (wrap to r0 not marked), `pending`=1.
  - Writeback `wb_en`=3, dest 31 -> `pending`=0.
- Simultaneous writeback r7 and accepted issue with dest 7 -> r7 remains busy, `pending` unchanged.
- Load several busy registers, assert `reset` asynchronously between edges:
  - `pending`, busy bits and all registers read 0 immediately;
  - writes while reset is asserted are ignored.
